// File: rtl/adf_sweep_ctrl.sv
// Frequency sweep sequencer for the ADF4351 configuration block: steps a kHz target
// from start to stop, handshakes each point with the configuration block, then dwells.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a valid START
// CFG      | issue the configuration request, arm the timeout
// WAIT     | waiting for the done pulse or timeout expiry
// DWELL    | point settled, holding for the dwell count
// STEP     | advance to the next point, wrap, or finish
module adf_sweep_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [23:0] start_freq_i,
    input  logic [23:0] stop_freq_i,
    input  logic [23:0] step_freq_i,
    input  logic [23:0] dwell_i,
    input  logic        continuous_i,
    input  logic        cfg_done_flag_i,
    output logic [23:0] freq_o,
    output logic        cfg_en_o,
    output logic        settled_o,
    output logic [15:0] step_idx_o,
    output logic        busy_o,
    output logic        sweep_done_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is loaded on CFG exit and expires on the TIMEOUT_CYCLES-th WAIT edge.
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT,
        ST_DWELL,
        ST_STEP
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   freq_q, freq_d;
    logic [15:0]   idx_q, idx_d;
    logic          cfg_en_q, cfg_en_d;
    logic          settled_q, settled_d;
    logic          busy_q, busy_d;
    logic          sweep_done_q, sweep_done_d;
    logic          err_q, err_d;
    logic          stop_pend_q, stop_pend_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [23:0]   dw_cnt_q, dw_cnt_d;
    logic [23:0]   start_sh_q, start_sh_d;
    logic [23:0]   stop_sh_q, stop_sh_d;
    logic [23:0]   step_sh_q, step_sh_d;
    logic [23:0]   dwell_sh_q, dwell_sh_d;
    logic          cont_sh_q, cont_sh_d;

    logic [24:0]   next_freq;
    logic          last_point;
    logic          cfg_valid;

    assign next_freq  = {1'b0, freq_q} + {1'b0, step_sh_q};
    assign last_point = (step_sh_q == 24'd0) || (next_freq > {1'b0, stop_sh_q});
    assign cfg_valid  = (start_freq_i >= 24'd35000) && (start_freq_i <= stop_freq_i) &&
                        (stop_freq_i <= 24'd4400000);

    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        idx_d        = idx_q;
        cfg_en_d     = 1'b0;
        settled_d    = 1'b0;
        busy_d       = busy_q;
        sweep_done_d = 1'b0;
        err_d        = err_q;
        stop_pend_d  = stop_pend_q;
        to_cnt_d     = to_cnt_q;
        dw_cnt_d     = dw_cnt_q;
        start_sh_d   = start_sh_q;
        stop_sh_d    = stop_sh_q;
        step_sh_d    = step_sh_q;
        dwell_sh_d   = dwell_sh_q;
        cont_sh_d    = cont_sh_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_valid) begin
                        start_sh_d  = start_freq_i;
                        stop_sh_d   = stop_freq_i;
                        step_sh_d   = step_freq_i;
                        dwell_sh_d  = dwell_i;
                        cont_sh_d   = continuous_i;
                        freq_d      = start_freq_i;
                        idx_d       = 16'd0;
                        busy_d      = 1'b1;
                        err_d       = 1'b0;
                        stop_pend_d = 1'b0;
                        state_d     = ST_CFG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                cfg_en_d = 1'b1;
                to_cnt_d = TO_LOAD;
                if (stop_i) stop_pend_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse on the expiry edge wins over the timeout.
                if (cfg_done_flag_i) begin
                    settled_d = 1'b1;
                    if (stop_pend_q || stop_i) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        dw_cnt_d = dwell_sh_q;
                        state_d  = ST_DWELL;
                    end
                end else if (to_cnt_q == '0) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                    if (stop_i) stop_pend_d = 1'b1;
                end
            end
            ST_DWELL: begin
                if (stop_i) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (dw_cnt_q == 24'd0) begin
                    state_d = ST_STEP;
                end else begin
                    dw_cnt_d = dw_cnt_q - 24'd1;
                end
            end
            ST_STEP: begin
                if (stop_i) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!last_point) begin
                    freq_d  = next_freq[23:0];
                    idx_d   = idx_q + 16'd1;
                    state_d = ST_CFG;
                end else if (cont_sh_q) begin
                    freq_d  = start_sh_q;
                    idx_d   = 16'd0;
                    state_d = ST_CFG;
                end else begin
                    sweep_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            freq_q       <= 24'd0;
            idx_q        <= 16'd0;
            cfg_en_q     <= 1'b0;
            settled_q    <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
            stop_pend_q  <= 1'b0;
            to_cnt_q     <= '0;
            dw_cnt_q     <= 24'd0;
            start_sh_q   <= 24'd0;
            stop_sh_q    <= 24'd0;
            step_sh_q    <= 24'd0;
            dwell_sh_q   <= 24'd0;
            cont_sh_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            idx_q        <= idx_d;
            cfg_en_q     <= cfg_en_d;
            settled_q    <= settled_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            err_q        <= err_d;
            stop_pend_q  <= stop_pend_d;
            to_cnt_q     <= to_cnt_d;
            dw_cnt_q     <= dw_cnt_d;
            start_sh_q   <= start_sh_d;
            stop_sh_q    <= stop_sh_d;
            step_sh_q    <= step_sh_d;
            dwell_sh_q   <= dwell_sh_d;
            cont_sh_q    <= cont_sh_d;
        end
    end

    assign freq_o       = freq_q;
    assign cfg_en_o     = cfg_en_q;
    assign settled_o    = settled_q;
    assign step_idx_o   = idx_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = sweep_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_adf_sweep_ctrl.sv
// Bench for adf_sweep_ctrl: a scoreboard queue of expected (freq, index) points is
// popped by a monitor on every configuration request; a model answers with done.
module tb_adf_sweep_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic        done = 1'b0;
    logic [23:0] sf = 24'd0, stf = 24'd0, stp = 24'd0, dw = 24'd0;
    logic [23:0] freq_o;
    logic        cfg_en_o, settled_o, busy_o, sweep_done_o, err_o;
    logic [15:0] step_idx_o;

    adf_sweep_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .start_freq_i(sf), .stop_freq_i(stf), .step_freq_i(stp), .dwell_i(dw),
        .continuous_i(cont), .cfg_done_flag_i(done),
        .freq_o(freq_o), .cfg_en_o(cfg_en_o), .settled_o(settled_o),
        .step_idx_o(step_idx_o), .busy_o(busy_o), .sweep_done_o(sweep_done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] f;
        logic [15:0] idx;
    } pt_t;

    pt_t exp_q[$];
    int  cfg_times[$];
    int  cyc = 0;
    int  n_chk = 0, n_err = 0;
    int  settled_cnt = 0, sdone_cnt = 0, cfgen_cnt = 0;
    bit  resp_en = 1'b1;
    int  resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Configuration-block model: done arrives 50 cycles after each request.
    always @(negedge clk) begin
        done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) done = 1'b1;
        end
        if (cfg_en_o && resp_en) resp_cnt = 50;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_en_o) begin
                pt_t p;
                cfgen_cnt++;
                cfg_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL cfg_en_unexpected: freq %0d idx %0d with no expected point",
                             freq_o, step_idx_o);
                end else begin
                    p = exp_q.pop_front();
                    check("cfg_freq", 32'(freq_o), 32'(p.f));
                    check("cfg_idx", 32'(step_idx_o), 32'(p.idx));
                end
            end
            if (settled_o) settled_cnt++;
            if (sweep_done_o) sdone_cnt++;
        end
    end

    task automatic setup(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                         input logic [23:0] d, input logic e);
        sf = a; stf = b; stp = c; dw = d; cont = e;
        cfg_times.delete();
    endtask

    task automatic push(input logic [23:0] f, input logic [15:0] idx);
        pt_t p;
        p.f = f;
        p.idx = idx;
        exp_q.push_back(p);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (busy_o && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy_o), 32'd0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    int s0, d0, c0, t0, n;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_freq", 32'(freq_o), 32'd0);
        check("reset_flags", {11'd0, step_idx_o, cfg_en_o, settled_o, busy_o, sweep_done_o, err_o}, 32'd0);
        rst_n = 1'b1;

        // Basic sweep
        setup(24'd100000, 24'd100300, 24'd100, 24'd10, 1'b0);
        push(24'd100000, 16'd0); push(24'd100100, 16'd1);
        push(24'd100200, 16'd2); push(24'd100300, 16'd3);
        s0 = settled_cnt; d0 = sdone_cnt;
        pulse_start();
        check("start_freq_latched", 32'(freq_o), 32'd100000);
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_cfg_en_not_yet", 32'(cfg_en_o), 32'd0);
        @(negedge clk);
        check("start_cfg_en_next", 32'(cfg_en_o), 32'd1);
        wait_idle("basic_idle", 2000);
        settle();
        check("basic_settled", settled_cnt - s0, 4);
        check("basic_sweep_done", sdone_cnt - d0, 1);
        check("basic_queue_left", exp_q.size(), 0);
        check("basic_err", 32'(err_o), 32'd0);
        check("basic_cfg_gap", (cfg_times.size() >= 2) ? cfg_times[1] - cfg_times[0] : 0, 64);

        // Non-aligned stop
        setup(24'd100000, 24'd100250, 24'd100, 24'd10, 1'b0);
        push(24'd100000, 16'd0); push(24'd100100, 16'd1); push(24'd100200, 16'd2);
        s0 = settled_cnt; d0 = sdone_cnt;
        pulse_start();
        wait_idle("nonaligned_idle", 2000);
        settle();
        check("nonaligned_settled", settled_cnt - s0, 3);
        check("nonaligned_sweep_done", sdone_cnt - d0, 1);
        check("nonaligned_queue_left", exp_q.size(), 0);

        // Zero step: single point
        setup(24'd100000, 24'd100300, 24'd0, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        s0 = settled_cnt; d0 = sdone_cnt;
        pulse_start();
        wait_idle("zerostep_idle", 1000);
        settle();
        check("zerostep_settled", settled_cnt - s0, 1);
        check("zerostep_sweep_done", sdone_cnt - d0, 1);
        check("zerostep_queue_left", exp_q.size(), 0);

        // Continuous mode with STOP in DWELL
        setup(24'd100000, 24'd100300, 24'd100, 24'd10, 1'b1);
        push(24'd100000, 16'd0); push(24'd100100, 16'd1);
        push(24'd100200, 16'd2); push(24'd100300, 16'd3);
        push(24'd100000, 16'd0); push(24'd100100, 16'd1);
        s0 = settled_cnt; d0 = sdone_cnt;
        pulse_start();
        n = 0;
        for (int i = 0; i < 1000 && n < 6; i++) begin
            @(negedge clk);
            if (settled_o) n++;
        end
        check("cont_settled_seen", n, 6);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("cont_stop_busy", 32'(busy_o), 32'd0);
        repeat (80) @(negedge clk);
        #1;
        check("cont_no_sweep_done", sdone_cnt - d0, 0);
        check("cont_settled_total", settled_cnt - s0, 6);
        check("cont_queue_left", exp_q.size(), 0);

        // STOP in WAIT_DONE
        setup(24'd100000, 24'd100300, 24'd100, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        s0 = settled_cnt; d0 = sdone_cnt;
        pulse_start();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("waitstop_idle", 500);
        repeat (80) @(negedge clk);
        #1;
        check("waitstop_settled", settled_cnt - s0, 1);
        check("waitstop_no_sweep_done", sdone_cnt - d0, 0);
        check("waitstop_queue_left", exp_q.size(), 0);

        // Timeout
        resp_en = 1'b0;
        setup(24'd100000, 24'd100300, 24'd100, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        pulse_start();
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 200 && !err_o; i++) @(negedge clk);
        check("timeout_latency", cyc - t0, 64);
        check("timeout_busy", 32'(busy_o), 32'd0);
        resp_en = 1'b1;
        setup(24'd100000, 24'd100300, 24'd0, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        pulse_start();
        check("restart_clears_err", 32'(err_o), 32'd0);
        wait_idle("restart_idle", 1000);
        settle();

        // Validation
        setup(24'd30000, 24'd100300, 24'd100, 24'd10, 1'b0);
        c0 = cfgen_cnt;
        pulse_start();
        check("inval_low_err", 32'(err_o), 32'd1);
        check("inval_low_busy", 32'(busy_o), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("inval_low_no_cfg", cfgen_cnt - c0, 0);
        setup(24'd100000, 24'd100300, 24'd0, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        pulse_start();
        check("valid_clears_err", 32'(err_o), 32'd0);
        wait_idle("valid_idle", 1000);
        settle();
        setup(24'd200000, 24'd100000, 24'd100, 24'd10, 1'b0);
        c0 = cfgen_cnt;
        pulse_start();
        check("inval_order_err", 32'(err_o), 32'd1);
        check("inval_order_busy", 32'(busy_o), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("inval_order_no_cfg", cfgen_cnt - c0, 0);

        // Reset during WAIT_DONE
        setup(24'd100000, 24'd100300, 24'd100, 24'd10, 1'b0);
        push(24'd100000, 16'd0);
        pulse_start();
        @(negedge clk);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_freq", 32'(freq_o), 32'd0);
        check("midrst_flags", {11'd0, step_idx_o, cfg_en_o, settled_o, busy_o, sweep_done_o, err_o}, 32'd0);
        s0 = settled_cnt; c0 = cfgen_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        #1;
        check("midrst_no_settled", settled_cnt - s0, 0);
        check("midrst_no_cfg", cfgen_cnt - c0, 0);
        check("midrst_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/adf_sweep_ctrl.md
# adf_sweep_ctrl

Upstream sequencer for the ADF4351 synthesizer configuration block. It steps a target frequency in kHz from a start value to a stop value. For each point it issues a one-cycle configuration request and waits for the configuration-done pulse. It then flags the point as settled for ADC capture and dwells before moving to the next point. It drives the `FREQ`/`CFG_EN` inputs of the configuration block and consumes its `CFG_DONE_FLAG`.

## Interface
- `TIMEOUT_CYCLES`, 1048576: maximum wait for `CFG_DONE_FLAG` per point before error.
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-low reset.
- `START` in 1: sweep start request, level-sampled, accepted only in IDLE.
- `STOP` in 1: sweep abort request, level-sampled.
- `START_FREQ` in 24: first point, kHz.
- `STOP_FREQ` in 24: upper sweep bound, kHz.
- `STEP_FREQ` in 24: increment, kHz.
- `DWELL` in 24: dwell length in CLK cycles after each settled point.
- `CONTINUOUS` in 1: 1 = restart from `START_FREQ` after the last point.
- `CFG_DONE_FLAG` in 1: one-cycle done pulse from the configuration block.
- `FREQ` out 24: target frequency to the configuration block.
- `CFG_EN` out 1: one-cycle configuration request.
- `SETTLED` out 1: one-cycle pulse when the current point is configured.
- `STEP_IDX` out 16: index of the current point, 0-based.
- `BUSY` out 1: high from START acceptance until return to IDLE.
- `SWEEP_DONE` out 1: one-cycle pulse at the end of a non-continuous sweep.
- `ERR` out 1: sticky error flag.

## Operation
- States: IDLE, CFG, WAIT_DONE, DWELL, STEP.
- All outputs are registered.
- Reset values: `FREQ`=0, `CFG_EN`=0, `SETTLED`=0, `STEP_IDX`=0, `BUSY`=0, `SWEEP_DONE`=0, `ERR`=0. State resets to IDLE and all counters to 0.
- IDLE with `START`=1, validation:
  - Valid requires 35000 ≤ `START_FREQ` ≤ `STOP_FREQ` ≤ 4400000.
  - If invalid: `ERR`<=1, stay in IDLE, no `CFG_EN`.
  - If valid: shadow-latch all sweep inputs, `FREQ`<=`START_FREQ`, `STEP_IDX`<=0, `BUSY`<=1, `ERR`<=0, go to CFG.
- Inputs are ignored after latching. Mid-sweep changes have no effect until the next START.
- CFG: `CFG_EN`=1 for exactly this cycle. Load the timeout counter and go to WAIT_DONE.
- WAIT_DONE:
  - On `CFG_DONE_FLAG`: `SETTLED` pulses, load the dwell counter with `DWELL`, go to DWELL.
  - If the timeout counter expires first: `ERR`<=1, `BUSY`<=0, go to IDLE.
  - `CFG_DONE_FLAG` outside WAIT_DONE is ignored.
- DWELL: count down. At 0 go to STEP. `DWELL`=0 means exactly one cycle in DWELL.
- STEP:
  - Compute `next` = `FREQ` + `STEP_FREQ` in 25 bits.
  - Last point when `STEP_FREQ`=0, or `next` > `STOP_FREQ`. No carry can escape, since `FREQ` ≤ 4400000.
  - Not last: `FREQ`<=`next`, `STEP_IDX`<=`STEP_IDX`+1 (mod 65536), go to CFG.
  - Last with `CONTINUOUS`=1: `FREQ`<=`START_FREQ`, `STEP_IDX`<=0, go to CFG.
  - Last with `CONTINUOUS`=0: `SWEEP_DONE` pulses, `BUSY`<=0, go to IDLE.
- `STOP_FREQ` is an upper bound. The final point is the highest `START_FREQ`+n·`STEP_FREQ` ≤ `STOP_FREQ`.
- STOP handling:
  - Sampled in DWELL or STEP: go to IDLE next cycle, `BUSY`<=0, no `SWEEP_DONE`.
  - Sampled in CFG or WAIT_DONE: latched. The point completes (done or timeout), `SETTLED` still pulses on done, then go to IDLE with no dwell.
  - Ignored in IDLE.
- `START` and `STOP` both high in IDLE: START wins.
- `ERR` is cleared only by reset or by an accepted valid START.

## Timing
- START sampled at edge k: `FREQ` is valid after edge k. `CFG_EN` is high between edges k+1 and k+2.
- `FREQ` is stable from one cycle before `CFG_EN` until the next STEP update, never changing while in WAIT_DONE.
- `CFG_DONE_FLAG` high at edge d: `SETTLED` is high between edges d and d+1.
- Next `CFG_EN` follows at d+`DWELL`+3, i.e. DWELL+1 cycles, STEP 1, CFG 1.
- Timeout: `ERR` rises `TIMEOUT_CYCLES` cycles after CFG exits if no done pulse arrives.
- A done pulse arriving in the same cycle as expiry counts as done, not error.
- Async reset mid-operation forces reset values immediately. No `CFG_EN` is issued until a new START.

## Test plan
- Basic sweep, with a model returning done 50 cycles after each `CFG_EN`:
  - Stimulus: `START_FREQ`=100000, `STOP_FREQ`=100300, `STEP_FREQ`=100, `DWELL`=10.
  - Response: 4 `CFG_EN` pulses with `FREQ`=100000/100100/100200/100300, `STEP_IDX` 0..3, 4 `SETTLED` pulses, then one `SWEEP_DONE` and `BUSY` low.
- Non-aligned stop: `STOP_FREQ`=100250, otherwise as above → 3 points, last `FREQ`=100200. `STEP_FREQ`=0 → single point then `SWEEP_DONE`.
- Continuous mode:
  - `CONTINUOUS`=1 with the basic-sweep settings → after 100300, `FREQ` returns to 100000 and `STEP_IDX` to 0.
  - STOP asserted in DWELL → IDLE next cycle, no `SWEEP_DONE`.
  - STOP asserted in WAIT_DONE → exactly one `SETTLED`, then IDLE.
- Timeout: `TIMEOUT_CYCLES`=64, model never answers → `ERR`=1 and `BUSY`=0 64 cycles after `CFG_EN`. A following valid START clears `ERR`.
- Validation: `START_FREQ`=30000, or `START_FREQ`=200000 with `STOP_FREQ`=100000 → `ERR`=1, `BUSY` stays 0, zero `CFG_EN` pulses.
- Reset during WAIT_DONE: all outputs return to reset values. A late `CFG_DONE_FLAG` produces no `SETTLED`.
